// File: rtl/pio_pkg.sv
// pio_pkg: shared constants and types for the PIO sequencer slice.
//   - PIO action codes (ACT_NONE / ACT_INSTR / ACT_PUSH)
//   - state machine count and datapath widths
//   - config ROM entry layout and sequencer state encoding
package pio_pkg;

  localparam int unsigned NUM_SM  = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CONF_W  = 36;
  localparam int unsigned ACT_W   = 4;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned MIDX_W  = $clog2(NUM_SM);

  localparam logic [ACT_W-1:0] ACT_NONE  = 4'd0;
  localparam logic [ACT_W-1:0] ACT_INSTR = 4'd1;
  localparam logic [ACT_W-1:0] ACT_PUSH  = 4'd4;

  // Config ROM word: action in the top nibble, PIO data below it.
  typedef struct packed {
    logic [ACT_W-1:0]  action;
    logic [DATA_W-1:0] data;
  } conf_entry_t;

  typedef enum logic [1:0] {
    LOAD_PROG = 2'd0,
    LOAD_CONF = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  // Instruction words occupy the low half of the PIO data bus.
  function automatic logic [DATA_W-1:0] instr_to_din(input logic [INSTR_W-1:0] word);
    return DATA_W'(word);
  endfunction

endpackage

// File: rtl/pio_rr_arbiter.sv
// pio_rr_arbiter: N-way round-robin arbiter with a pre-qualified eligibility
// vector. Grant is combinational; the pointer advances past the winner.
//   clk, reset   : clock, async active-high reset (pointer -> 0)
//   eligible     : requesters allowed to win this cycle
//   grant        : one-hot winner (zero when nothing is eligible)
//   grant_valid  : any winner this cycle
//   grant_idx    : binary index of the winner
module pio_rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  eligible,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_d;
  int unsigned   cand;
  logic [IW-1:0] cidx;

  // First eligible requester at or after the pointer, wrapping.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = 0;
    cidx        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      cidx = IW'(cand);
      if (!grant_valid && eligible[cidx]) begin
        grant_valid = 1'b1;
        grant_idx   = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

  // Pointer moves to the requester after the winner.
  always_comb begin
    ptr_d = ptr;
    if (grant_valid) begin
      ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_d;
    end
  end

endmodule

// File: rtl/pio_sequencer.sv
// pio_sequencer: loads the PIO program and configuration after reset, then
// arbitrates the four TX-FIFO push requesters onto the PIO write port.
//   clk, reset          : clock, async active-high reset
//   restart             : pulse in RUN to rerun the whole load
//   prog_addr/prog_data : program ROM port (1-cycle synchronous read)
//   conf_addr/conf_data : config ROM port (1-cycle synchronous read)
//   req_valid/req_data  : per-machine push requests
//   req_ready           : combinational grant
//   full                : per-machine TX-FIFO full flags
//   action/din/index/mindex : registered PIO write port
//   loaded              : high while running after a completed load
module pio_sequencer
  import pio_pkg::*;
#(
  parameter int unsigned PROG_LEN = 32,
  parameter int unsigned CONF_LEN = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     restart,
  output logic [ADDR_W-1:0]        prog_addr,
  input  logic [INSTR_W-1:0]       prog_data,
  output logic [ADDR_W-1:0]        conf_addr,
  input  logic [CONF_W-1:0]        conf_data,
  input  logic [NUM_SM-1:0]        req_valid,
  input  logic [NUM_SM*DATA_W-1:0] req_data,
  output logic [NUM_SM-1:0]        req_ready,
  input  logic [NUM_SM-1:0]        full,
  output logic [ACT_W-1:0]         action,
  output logic [DATA_W-1:0]        din,
  output logic [IDX_W-1:0]         index,
  output logic [MIDX_W-1:0]        mindex,
  output logic                     loaded
);

  // One extra bit so a count of 32 is representable.
  localparam int unsigned CNT_W = ADDR_W + 1;

  seq_state_t        state, state_d;
  logic [CNT_W-1:0]  prog_cnt, prog_cnt_d;
  logic [CNT_W-1:0]  conf_cnt, conf_cnt_d;
  logic              pend_prog, pend_prog_d;
  logic              pend_conf, pend_conf_d;
  logic [IDX_W-1:0]  pend_idx, pend_idx_d;
  logic [ACT_W-1:0]  action_d;
  logic [DATA_W-1:0] din_d;
  logic [IDX_W-1:0]  index_d;
  logic [MIDX_W-1:0] mindex_d;
  logic              loaded_d;
  logic [NUM_SM-1:0] lastmask, lastmask_d;

  logic [NUM_SM-1:0] eligible;
  logic [NUM_SM-1:0] grant;
  logic              grant_valid;
  logic [MIDX_W-1:0] grant_idx;
  conf_entry_t       conf_entry;

  assign prog_addr  = prog_cnt[ADDR_W-1:0];
  assign conf_addr  = conf_cnt[ADDR_W-1:0];
  assign conf_entry = conf_entry_t'(conf_data);

  // Machines granted last cycle sit out one cycle so their full flag can catch up.
  assign eligible  = (state == RUN && !restart) ? (req_valid & ~full & ~lastmask) : '0;
  assign req_ready = grant;

  pio_rr_arbiter #(
    .N (NUM_SM)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .eligible    (eligible),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next state, ROM address sequencing and next PIO write-port values.
  always_comb begin
    state_d     = state;
    prog_cnt_d  = prog_cnt;
    conf_cnt_d  = conf_cnt;
    pend_prog_d = 1'b0;
    pend_conf_d = 1'b0;
    pend_idx_d  = pend_idx;
    action_d    = ACT_NONE;
    din_d       = din;
    index_d     = index;
    mindex_d    = mindex;
    lastmask_d  = grant;

    case (state)
      LOAD_PROG: begin
        // Every cycle issues one ROM read; its data is written out two edges later.
        pend_prog_d = 1'b1;
        pend_idx_d  = prog_addr;
        prog_cnt_d  = prog_cnt + CNT_W'(1);
        if (prog_cnt == CNT_W'(PROG_LEN - 1)) begin
          state_d = LOAD_CONF;
        end
      end
      LOAD_CONF: begin
        // The cycle with no read left lets the final write drain before RUN.
        if (conf_cnt == CNT_W'(CONF_LEN)) begin
          state_d = RUN;
        end else begin
          pend_conf_d = 1'b1;
          conf_cnt_d  = conf_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        prog_cnt_d = '0;
        conf_cnt_d = '0;
        if (restart) begin
          state_d = LOAD_PROG;
        end
      end
      default: begin
        state_d = LOAD_PROG;
      end
    endcase

    // Load traffic and RUN grants never overlap, so a simple priority mux suffices.
    if (pend_prog) begin
      action_d = ACT_INSTR;
      index_d  = pend_idx;
      din_d    = instr_to_din(prog_data);
      mindex_d = '0;
    end else if (pend_conf) begin
      action_d = conf_entry.action;
      din_d    = conf_entry.data;
      mindex_d = '0;
    end else if (grant_valid) begin
      action_d = ACT_PUSH;
      mindex_d = grant_idx;
      for (int unsigned i = 0; i < NUM_SM; i++) begin
        if (grant[i]) begin
          din_d = req_data[i*DATA_W +: DATA_W];
        end
      end
    end

    // Rises one cycle into RUN (after the last config write), drops as RUN is left.
    loaded_d = (state == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD_PROG;
      prog_cnt  <= '0;
      conf_cnt  <= '0;
      pend_prog <= 1'b0;
      pend_conf <= 1'b0;
      pend_idx  <= '0;
      action    <= ACT_NONE;
      din       <= '0;
      index     <= '0;
      mindex    <= '0;
      loaded    <= 1'b0;
      lastmask  <= '0;
    end else begin
      state     <= state_d;
      prog_cnt  <= prog_cnt_d;
      conf_cnt  <= conf_cnt_d;
      pend_prog <= pend_prog_d;
      pend_conf <= pend_conf_d;
      pend_idx  <= pend_idx_d;
      action    <= action_d;
      din       <= din_d;
      index     <= index_d;
      mindex    <= mindex_d;
      loaded    <= loaded_d;
      lastmask  <= lastmask_d;
    end
  end

endmodule

// File: tb/tb_pio_sequencer.sv
// tb_pio_sequencer: randomized bench for pio_sequencer with a timeline-based
// reference model and a few hand-computed anchor checks.
module tb_pio_sequencer;

  localparam int P = 32;
  localparam int C = 3;

  logic         clk;
  logic         reset;
  logic         restart;
  logic [4:0]   prog_addr;
  logic [15:0]  prog_data;
  logic [4:0]   conf_addr;
  logic [35:0]  conf_data;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   full;
  logic [3:0]   action;
  logic [31:0]  din;
  logic [4:0]   index;
  logic [1:0]   mindex;
  logic         loaded;

  int checks = 0;
  int errors = 0;

  logic [35:0] conf_rom [0:31];

  pio_sequencer #(.PROG_LEN(P), .CONF_LEN(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .conf_addr (conf_addr),
    .conf_data (conf_data),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .action    (action),
    .din       (din),
    .index     (index),
    .mindex    (mindex),
    .loaded    (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROMs: program word i is 16'hA000 + i.
  always @(posedge clk) begin
    prog_data <= 16'hA000 + 16'(prog_addr);
    conf_data <= conf_rom[conf_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model + compare ----------------
  int          lt;        // cycles since the current load began
  int          m_ptr;
  logic [3:0]  m_last;
  logic [3:0]  m_action;
  logic [31:0] m_din;
  logic [4:0]  m_index;
  logic [1:0]  m_mindex;

  always @(negedge clk) begin
    int g;
    int u;
    int j;
    int i;
    logic [3:0] exp_ready;
    if (reset) begin
      chk("rst_action", 32'(action), 0);
      chk("rst_din", din, 0);
      chk("rst_index", 32'(index), 0);
      chk("rst_mindex", 32'(mindex), 0);
      chk("rst_loaded", 32'(loaded), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_prog_addr", 32'(prog_addr), 0);
      chk("rst_conf_addr", 32'(conf_addr), 0);
      lt = 0; m_ptr = 0; m_last = '0;
      m_action = '0; m_din = '0; m_index = '0; m_mindex = '0;
    end else begin
      chk("action", 32'(action), 32'(m_action));
      chk("din", din, m_din);
      chk("index", 32'(index), 32'(m_index));
      chk("mindex", 32'(mindex), 32'(m_mindex));
      chk("loaded", 32'(loaded), 32'(lt >= P + C + 2));
      if (lt < P) chk("prog_addr", 32'(prog_addr), 32'(lt));
      if (lt >= P && lt < P + C) chk("conf_addr", 32'(conf_addr), 32'(lt - P));

      // anchors computed by hand for P=32, C=3 with the bench ROM contents
      if (lt == 2)  begin chk("pin_w0_act", 32'(action), 1); chk("pin_w0_din", din, 32'h0000A000); end
      if (lt == 33) begin chk("pin_w31_idx", 32'(index), 31); chk("pin_w31_din", din, 32'h0000A01F); end
      if (lt == 34) begin chk("pin_c0_act", 32'(action), 2); chk("pin_c0_din", din, 1); end
      if (lt == 35) chk("pin_c1_act", 32'(action), 0);
      if (lt == 36) begin chk("pin_c2_act", 32'(action), 3); chk("pin_c2_din", din, 5); chk("pin_c2_loaded", 32'(loaded), 0); end
      if (lt == 37) chk("pin_loaded_rise", 32'(loaded), 1);

      // arbitration in this cycle
      g = -1;
      if (lt >= P + C + 1 && !restart) begin
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr + k) % 4;
          if (g < 0 && req_valid[i] && !full[i] && !m_last[i]) g = i;
        end
      end
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));

      // write-port contents for the next cycle
      u = lt + 1;
      if (u >= 2 && u <= P + 1) begin
        m_action = 4'd1; m_index = 5'(u - 2); m_din = 32'hA000 + 32'(u - 2); m_mindex = 2'd0;
      end else if (u >= P + 2 && u <= P + C + 1) begin
        j = u - P - 2;
        m_action = conf_rom[j][35:32]; m_din = conf_rom[j][31:0]; m_mindex = 2'd0;
      end else if (g >= 0) begin
        m_action = 4'd4; m_mindex = 2'(g); m_din = req_data[g*32 +: 32];
      end else begin
        m_action = 4'd0;
      end
      m_last = exp_ready;
      if (g >= 0) m_ptr = (g + 1) % 4;
      lt = (lt >= P + C + 1 && restart) ? 0 : lt + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    logic [3:0] grants [0:4];
    int cnt2;
    int cnt1;
    for (int k = 0; k < 32; k++) conf_rom[k] = '0;
    conf_rom[0] = {4'h2, 32'h1};
    conf_rom[1] = {4'h0, 32'($urandom())};
    conf_rom[2] = {4'h3, 32'h5};

    reset = 1'b1; restart = 1'b0; req_valid = 4'hF; full = 4'h0; req_data = '0;
    repeat (3) step();
    reset = 1'b0;

    // all machines requesting from the first RUN cycle
    repeat (P + C + 1) step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      grants[k] = req_ready;
      step();
    end
    chk("rr_g0", 32'(grants[0]), 32'h1);
    chk("rr_g1", 32'(grants[1]), 32'h2);
    chk("rr_g2", 32'(grants[2]), 32'h4);
    chk("rr_g3", 32'(grants[3]), 32'h8);
    chk("rr_g4", 32'(grants[4]), 32'h1);

    // single requester: every other cycle
    req_valid = 4'b0100;
    cnt2 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_ready[2]) cnt2++;
      step();
    end
    chk("single_sm_grants", 32'(cnt2), 4);

    // machine 1 blocked by full, machine 3 alternates alone
    req_valid = 4'b1010; full = 4'b0010;
    cnt1 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req_ready[1]) cnt1++;
      step();
    end
    chk("full_blocks_sm1", 32'(cnt1), 0);
    full = 4'b0000;
    repeat (6) step();

    // randomized traffic with occasional restarts
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom());
      full      = 4'($urandom() & $urandom());
      restart   = ($urandom_range(0, 99) == 0);
      step();
    end
    restart = 1'b0; req_valid = 4'hF; full = 4'h0;
    repeat (P + C + 4) step();

    // restart with everyone requesting, then reset in the middle of the reload
    restart = 1'b1;
    @(negedge clk);
    chk("restart_no_grant", 32'(req_ready), 0);
    step();
    restart = 1'b0;
    repeat (10) step();
    chk("reload_addr10", 32'(prog_addr), 10);
    reset = 1'b1;
    #1;
    chk("async_rst_action", 32'(action), 0);
    chk("async_rst_index", 32'(index), 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (P + C + 10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
